hilbert_cordic_polar: RTL and testbench
=======================================

Name: hilbert_cordic_polar

Overview:
- Sits directly downstream of the Hilbert FIR stage.
- Consumes the FIR's 13-bit signed analytic pair (Re, Im) once per sample strobe.
- Computes magnitude (envelope) and phase with an iterative vectoring CORDIC, one micro-rotation per enabled clock.
- Fits easily inside the FIR's 20-clock sample cadence.

Parameters:
- ITER, 12: number of CORDIC micro-rotations. Legal range 1..12; the angle table holds 12 entries.
- PHASE_W, 16: phase width. Binary angle: 2^PHASE_W = full circle, 0x8000 = pi. Fixed at 16 in this revision.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- EN  input  1  clock enable; FSM and datapath advance only when EN=1.
- start  input  1  sample strobe; Re/Im are valid in this cycle.
- Re  input  13  signed real part from the FIR.
- Im  input  13  signed imaginary part from the FIR.
- Mag  output  14  unsigned magnitude.
- Phase  output  16  signed binary-angle phase of (Re, Im).
- busy  output  1  computation in progress.
- done  output  1  one-clock pulse when Mag/Phase update.

Behaviour:
- Reset (asynchronous, reset=0): FSM=IDLE; Mag=0, Phase=0, busy=0, done=0; x, y, z and iteration counter all 0. Reset asserted mid-computation aborts the computation; no done pulse is produced.
- FSM states: IDLE -> ROT -> OUT -> IDLE.
- IDLE, on EN & start (accept edge):
  - Latch and pre-rotate into 16-bit signed x, y and 16-bit z.
  - If Re<0: x=-Re, y=-Im, z=0x8000. Else: x=Re, y=Im, z=0.
  - Set zero flag = (Re==0 && Im==0).
  - Set i=0, busy=1, go to ROT.
- ROT, each EN cycle:
  - If y>=0: x+=y>>>i, y-=x>>>i, z+=A[i].
  - Else: x-=y>>>i, y+=x>>>i, z-=A[i].
  - Shifts are arithmetic and truncating; all updates use the old x/y values. z wraps modulo 2^16.
  - i increments; after iteration ITER-1, go to OUT.
- A[0..11] = 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5.
- OUT, on EN:
  - Mag = x[13:0] (after optional gain compensation).
  - Phase = zero flag ? 0 : z.
  - done=1, busy=0, go to IDLE.
- Latency: the output edge is the (ITER+1)th EN edge after the accept edge, i.e. 13 enabled clocks at ITER=12.
- done clears on the next clock edge regardless of EN. Mag/Phase hold their value until the next output edge.
- EN=0 freezes the FSM and all registers (except done clearing).
- start while busy=1 is ignored with no queueing. start in the cycle done=1 is accepted (FSM is in IDLE).
- Range: worst case |x| ≈ 4096·√2·1.647 ≈ 9540, which fits 14 bits unsigned and 16 bits internal. Re = -4096 negates to 4096 without overflow.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined: at OUT, Mag = (x · 19899) >> 15, truncated (compensates the 1/1.64676 CORDIC gain). Registered in the same OUT cycle; latency unchanged.
- Undefined: Mag = raw x, carrying the ~1.647 CORDIC gain; no multiplier is synthesised.

Test Plan:
- Re=1000, Im=0, start, EN=1 -> done exactly 13 clocks after accept. Phase within 0±8. Mag = 1647±3 (raw) or 1000±3 (comp).
- Re=0, Im=1000 -> Phase 16384±8; Mag as above.
- Re=-1000, Im=0 -> Phase -32768±8; test must pass across the +pi/-pi wrap. Re=-4096, Im=-4096 -> Phase -24576±8; Mag 9540±6 (raw) or 5793±4 (comp).
- Re=Im=0 -> Mag=0, Phase=0, done pulses once.
- start re-pulsed with different data on every clock while busy -> those starts ignored; output reflects only the first sample. Toggle EN 50% -> latency is exactly 13 EN-high cycles, results unchanged.
- reset driven low mid-ROT (asynchronous, between clock edges) -> busy, done, Mag, Phase go 0 immediately; no done pulse after release; the next start computes correctly.

Source files
------------

// File: rtl/hilbert_cordic_polar.sv
// Iterative vectoring CORDIC: (Re, Im) -> envelope magnitude and binary-angle phase.
// Define CORDIC_GAIN_COMP_EN to scale Mag by 1/1.64676 at the output stage.
module hilbert_cordic_polar #(
    parameter int ITER    = 12,
    parameter int PHASE_W = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      EN,
    input  logic                      start,
    input  logic signed [12:0]        Re,
    input  logic signed [12:0]        Im,
    output logic [13:0]               Mag,
    output logic signed [PHASE_W-1:0] Phase,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, ROT, OUT} state_t;

    state_t               state;
    logic signed [15:0]   x;
    logic signed [15:0]   y;
    logic [PHASE_W-1:0]   z;
    logic [3:0]           i;
    logic                 zero;

    logic signed [15:0]   re_w;
    logic signed [15:0]   im_w;
    logic signed [15:0]   xs;
    logic signed [15:0]   ys;
    logic signed [15:0]   x_nx;
    logic signed [15:0]   y_nx;
    logic [PHASE_W-1:0]   z_nx;
    logic [13:0]          mag_nx;
    logic [PHASE_W-1:0]   ang;

    function automatic logic [15:0] atan_lut(input logic [3:0] k);
        case (k)
            4'd0:    return 16'd8192;
            4'd1:    return 16'd4836;
            4'd2:    return 16'd2555;
            4'd3:    return 16'd1297;
            4'd4:    return 16'd651;
            4'd5:    return 16'd326;
            4'd6:    return 16'd163;
            4'd7:    return 16'd81;
            4'd8:    return 16'd41;
            4'd9:    return 16'd20;
            4'd10:   return 16'd10;
            4'd11:   return 16'd5;
            default: return 16'd0;
        endcase
    endfunction

    assign re_w = {{3{Re[12]}}, Re};
    assign im_w = {{3{Im[12]}}, Im};
    assign xs   = x >>> i;
    assign ys   = y >>> i;
    assign ang  = atan_lut(i);

    // Rotate toward y = 0; both updates read the pre-rotation x/y.
    always_comb begin
        x_nx = x;
        y_nx = y;
        z_nx = z;
        if (!y[15]) begin
            x_nx = x + ys;
            y_nx = y - xs;
            z_nx = z + ang;
        end else begin
            x_nx = x - ys;
            y_nx = y + xs;
            z_nx = z - ang;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    logic [31:0] prod;
    assign prod   = {16'd0, x} * 32'd19899;
    assign mag_nx = 14'(prod >> 15);
`else
    assign mag_nx = x[13:0];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            i     <= '0;
            zero  <= 1'b0;
            Mag   <= '0;
            Phase <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (EN) begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            // Fold the left half-plane onto the right, carrying pi in z.
                            if (Re[12]) begin
                                x <= -re_w;
                                y <= -im_w;
                                z <= PHASE_W'(16'h8000);
                            end else begin
                                x <= re_w;
                                y <= im_w;
                                z <= '0;
                            end
                            zero  <= (Re == '0) && (Im == '0);
                            i     <= '0;
                            busy  <= 1'b1;
                            state <= ROT;
                        end
                    end
                    ROT: begin
                        x <= x_nx;
                        y <= y_nx;
                        z <= z_nx;
                        i <= i + 4'd1;
                        if (i == 4'(ITER - 1))
                            state <= OUT;
                    end
                    OUT: begin
                        Mag   <= mag_nx;
                        Phase <= zero ? '0 : z;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilbert_cordic_polar.sv
// Bench for hilbert_cordic_polar: directed corners plus random vectors
// compared against a floating-point polar model.
module tb_hilbert_cordic_polar;

    localparam int LAT = 13;
    localparam real PI = 3.141592653589793;

    logic               clock;
    logic               reset;
    logic               EN;
    logic               start;
    logic signed [12:0] Re;
    logic signed [12:0] Im;
    logic [13:0]        Mag;
    logic signed [15:0] Phase;
    logic               busy;
    logic               done;

    int n_chk;
    int n_fail;

    hilbert_cordic_polar dut (
        .clock (clock),
        .reset (reset),
        .EN    (EN),
        .start (start),
        .Re    (Re),
        .Im    (Im),
        .Mag   (Mag),
        .Phase (Phase),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic near(input string tag, input int obs, input int exp,
                        input int tol, input bit wrap);
        int d;
        d = obs - exp;
        if (wrap) begin
            d = d % 65536;
            if (d > 32767) d -= 65536;
            if (d < -32768) d += 65536;
        end
        n_chk++;
        assert ((d <= tol) && (d >= -tol)) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d",
                   tag, obs, exp, tol);
        end
    endtask

    function automatic int ref_mag(input int re, input int im);
        real h;
        h = $sqrt(real'(re * re + im * im)) * 1.646760;
`ifdef CORDIC_GAIN_COMP_EN
        h = h * 19899.0 / 32768.0;
`endif
        return int'(h);
    endfunction

    function automatic int ref_ph(input int re, input int im);
        return int'($atan2(real'(im), real'(re)) * 32768.0 / PI);
    endfunction

    task automatic run(input int re, input int im, input bit toggle,
                       input bit spam, output int mag, output int ph);
        logic [31:0] r;
        int lat;
        bit ok;
        @(negedge clock);
        EN = 1'b1;
        start = 1'b1;
        Re = 13'(re);
        Im = 13'(im);
        @(posedge clock);
        #1;
        chk("busy_accept", 32'(busy), 32'd1);
        lat = 0;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clock);
            EN = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (spam) begin
                r = $urandom;
                start = 1'b1;
                Re = r[12:0];
                Im = r[28:16];
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            if (EN) lat++;
            #1;
            if (done) ok = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 32'(ok), 32'd1);
        chk("latency", 32'(lat), 32'(LAT));
        chk("busy_at_done", 32'(busy), 32'd0);
        mag = int'(Mag);
        ph = int'(Phase);
    endtask

    int d_re[4]  = '{1000, 0, -1000, -4096};
    int d_im[4]  = '{0, 1000, 0, -4096};
    int d_ph[4]  = '{0, 16384, -32768, -24576};
`ifdef CORDIC_GAIN_COMP_EN
    int d_mag[4] = '{1000, 1000, 1000, 5793};
    int d_tol[4] = '{3, 3, 3, 4};
    localparam int MTOL = 12;
`else
    int d_mag[4] = '{1647, 1647, 1647, 9540};
    int d_tol[4] = '{3, 3, 3, 6};
    localparam int MTOL = 16;
`endif

    initial begin
        int m;
        int p;
        int re;
        int im;
        int seen;
        n_chk = 0;
        n_fail = 0;
        clock = 1'b0;
        reset = 1'b0;
        EN = 1'b0;
        start = 1'b0;
        Re = '0;
        Im = '0;

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mag", 32'(Mag), 32'd0);
        chk("rst_phase", 32'(Phase), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int k = 0; k < 4; k++) begin
            run(d_re[k], d_im[k], 1'b0, 1'b0, m, p);
            near("dir_mag", m, d_mag[k], d_tol[k], 1'b0);
            near("dir_phase", p, d_ph[k], 8, 1'b1);
        end

        run(0, 0, 1'b0, 1'b0, m, p);
        chk("zero_mag", 32'(m), 32'd0);
        chk("zero_phase", 32'(p), 32'd0);
        @(negedge clock);
        EN = 1'b0;
        @(posedge clock);
        #1;
        chk("done_clears_en0", 32'(done), 32'd0);
        run(2500, -1800, 1'b0, 1'b0, m, p);
        @(negedge clock);
        EN = 1'b0;
        @(posedge clock);
        #1;
        chk("done_clears", 32'(done), 32'd0);
        chk("mag_hold", 32'(Mag), 32'(m));

        run(2500, -1800, 1'b0, 1'b1, m, p);
        near("spam_mag", m, ref_mag(2500, -1800), MTOL, 1'b0);
        near("spam_phase", p, ref_ph(2500, -1800), 64, 1'b1);

        run(-3000, 1500, 1'b1, 1'b0, m, p);
        near("tog_mag", m, ref_mag(-3000, 1500), MTOL, 1'b0);
        near("tog_phase", p, ref_ph(-3000, 1500), 64, 1'b1);

        @(negedge clock);
        EN = 1'b1;
        start = 1'b1;
        Re = 13'sd1000;
        Im = 13'sd500;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_mag", 32'(Mag), 32'd0);
        chk("mid_rst_phase", 32'(Phase), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (done) seen++;
        end
        chk("no_done_after_rst", 32'(seen), 32'd0);
        run(-2200, -2900, 1'b0, 1'b0, m, p);
        near("post_rst_mag", m, ref_mag(-2200, -2900), MTOL, 1'b0);
        near("post_rst_phase", p, ref_ph(-2200, -2900), 64, 1'b1);

        for (int k = 0; k < 12; k++) begin
            do begin
                re = int'($urandom_range(0, 8191)) - 4096;
                im = int'($urandom_range(0, 8191)) - 4096;
            end while (re * re + im * im < 2000 * 2000);
            run(re, im, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m, p);
            near("rnd_mag", m, ref_mag(re, im), MTOL, 1'b0);
            near("rnd_phase", p, ref_ph(re, im), 64, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
